config_loader: RTL
==================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter NUM_CONFIG, default 18, the number of config words after total_level (the eight "or_not" flags are merged into one word).
REQ-002 SHALL have parameter CONFIG_BIT_SIZE, default 13, the config word width.
REQ-003 SHALL have parameter LEVEL_BIT_SIZE, default 3, the total_level width.
REQ-004 SHALL have parameter MAX_LEVEL, default 4, the largest legal total_level.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cfg_start, input, 1, a one-cycle pulse that begins or restarts a load.
REQ-008 SHALL have port cfg_valid, input, 1, meaning cfg_data holds a word.
REQ-009 SHALL have port cfg_ready, output, 1, meaning the block accepts a word this cycle.
REQ-010 SHALL have port cfg_data, input, CONFIG_BIT_SIZE, the incoming word.
REQ-011 SHALL have port config_bus, output, NUM_CONFIG*CONFIG_BIT_SIZE, the active config set; word i sits at [i*CONFIG_BIT_SIZE +: CONFIG_BIT_SIZE].
REQ-012 SHALL have port total_level, output, LEVEL_BIT_SIZE, the active pyramid level count.
REQ-013 SHALL have port config_done, output, 1, a level signal meaning the active set is valid for the ISP core.
REQ-014 SHALL have port load_error, output, 1, a sticky flag set when an illegal level is received.

Function
REQ-015 SHALL implement FSM states IDLE, LEVEL, CFG and DONE.
REQ-016 SHALL drive cfg_ready = (state==LEVEL or state==CFG) and !cfg_start, combinationally; a handshake is cfg_valid and cfg_ready on the same edge.
REQ-017 SHALL, in IDLE or DONE, move to LEVEL on cfg_start, clear load_error, clear config_done and reset the word index to 0.
REQ-018 SHALL, in LEVEL on a handshake, check cfg_data: legal means cfg_data[LEVEL_BIT_SIZE-1:0] in 1..MAX_LEVEL and all upper bits 0.
REQ-019 SHALL, on a legal level word, latch it into a shadow level register and move to CFG.
REQ-020 SHALL, on an illegal level word, set load_error, go to IDLE and leave the active set unchanged.
REQ-021 SHALL, in CFG, write each handshake word into shadow[index] and increment the index.
REQ-022 SHALL, on the handshake at index NUM_CONFIG-1, copy all shadow words and the shadow level to config_bus/total_level on that edge, assert config_done from the next cycle and enter DONE.
REQ-023 SHALL give a latency from the last handshake to visible config_bus/config_done of exactly one cycle.
REQ-024 SHALL hold config_bus and total_level constant except at a commit (REQ-022); a new load does not disturb them until it commits.
REQ-025 SHALL treat cfg_start in LEVEL or CFG as an abort-and-restart: go to LEVEL, reset index to 0, discard shadow contents, accept no word that cycle; config_done stays 0.
REQ-026 SHALL give cfg_start priority over cfg_valid in every state.
REQ-027 SHALL ignore cfg_valid whenever cfg_ready=0, with no state change.
REQ-028 SHALL keep the index width at $clog2(NUM_CONFIG) with no wrap; the index never exceeds NUM_CONFIG-1.
REQ-029 SHALL keep DONE until cfg_start; extra cfg_valid words in DONE are dropped.

Reset
REQ-030 SHALL, while reset=1 at an edge, set state=IDLE, index=0, config_bus=0, total_level=0, config_done=0, load_error=0 and clear the shadow registers.
REQ-031 SHALL let reset override cfg_start and any handshake in the same cycle, and abort a load in progress.

Verification
REQ-032 SHALL cover a nominal load: cfg_start, level 3, words 1..18 with valid held high -> cfg_ready high for 19 cycles, config_done=1 one cycle after word 18, total_level=3, word i at slice i equal to i+1.
REQ-033 SHALL cover backpressure: valid toggled randomly during the load -> the same final config_bus, and only valid&ready cycles advance the index.
REQ-034 SHALL cover an illegal level: level word 0, then 5, then 13'h008 -> load_error=1 each time, state IDLE, prior config_bus/total_level unchanged, config_done=0.
REQ-035 SHALL cover an abort: cfg_start after 7 config words, then a full load of level 2 with words 0x100.. -> no commit of the partial load; the final bus holds only the second set.
REQ-036 SHALL cover a reload over an active set: config_bus holds set A, a new load of set B runs -> config_done=0 during the load, the bus holds A until the final handshake and B one cycle later.
REQ-037 SHALL cover reset mid-load: reset at word 10 -> all outputs 0 next cycle, cfg_ready=0, a new cfg_start is required.

Source files
------------

// File: rtl/config_loader.sv
// Loads a pyramid level word followed by NUM_CONFIG config words into shadow registers,
// then commits the whole set to the active outputs on the final handshake.
//
// state | meaning
// IDLE  | no load in progress; active set (if any) held
// LEVEL | waiting for the total_level word
// CFG   | collecting config words into the shadow registers
// DONE  | active set committed and valid; waiting for the next cfg_start
module config_loader #(
    parameter int NUM_CONFIG      = 18,
    parameter int CONFIG_BIT_SIZE = 13,
    parameter int LEVEL_BIT_SIZE  = 3,
    parameter int MAX_LEVEL       = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_start,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [CONFIG_BIT_SIZE-1:0]            cfg_data,
    output logic [NUM_CONFIG*CONFIG_BIT_SIZE-1:0] config_bus,
    output logic [LEVEL_BIT_SIZE-1:0]             total_level,
    output logic                                  config_done,
    output logic                                  load_error
);

    localparam int IDX_W = (NUM_CONFIG > 1) ? $clog2(NUM_CONFIG) : 1;

    typedef enum logic [1:0] {IDLE, LEVEL, CFG, DONE} state_t;

    state_t                      state, state_nxt;
    logic [IDX_W-1:0]            index;
    logic [CONFIG_BIT_SIZE-1:0]  shadow [NUM_CONFIG];
    logic [LEVEL_BIT_SIZE-1:0]   shadow_level;
    logic                        handshake;
    logic                        level_legal;
    logic                        last_word;

    always_comb begin
        cfg_ready   = ((state == LEVEL) || (state == CFG)) && !cfg_start;
        handshake   = cfg_valid && cfg_ready;
        last_word   = (index == IDX_W'(NUM_CONFIG - 1));
        level_legal = ((cfg_data >> LEVEL_BIT_SIZE) == '0) &&
                      (cfg_data[LEVEL_BIT_SIZE-1:0] != '0) &&
                      (cfg_data[LEVEL_BIT_SIZE-1:0] <= LEVEL_BIT_SIZE'(MAX_LEVEL));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (cfg_start) state_nxt = LEVEL;
            LEVEL: begin
                if (cfg_start)      state_nxt = LEVEL;
                else if (handshake) state_nxt = level_legal ? CFG : IDLE;
            end
            CFG: begin
                if (cfg_start)                   state_nxt = LEVEL;
                else if (handshake && last_word) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            index        <= '0;
            shadow_level <= '0;
            config_bus   <= '0;
            total_level  <= '0;
            config_done  <= 1'b0;
            load_error   <= 1'b0;
            for (int i = 0; i < NUM_CONFIG; i++) shadow[i] <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_start) begin
                // start or restart: previous shadow contents are discarded
                index        <= '0;
                shadow_level <= '0;
                config_done  <= 1'b0;
                load_error   <= 1'b0;
                for (int i = 0; i < NUM_CONFIG; i++) shadow[i] <= '0;
            end else if (handshake) begin
                if (state == LEVEL) begin
                    if (level_legal) shadow_level <= cfg_data[LEVEL_BIT_SIZE-1:0];
                    else             load_error   <= 1'b1;
                end else if (state == CFG) begin
                    shadow[index] <= cfg_data;
                    if (last_word) begin
                        // final word bypasses its shadow slot so the commit lands on this edge
                        for (int i = 0; i < NUM_CONFIG - 1; i++)
                            config_bus[i*CONFIG_BIT_SIZE +: CONFIG_BIT_SIZE] <= shadow[i];
                        config_bus[(NUM_CONFIG-1)*CONFIG_BIT_SIZE +: CONFIG_BIT_SIZE] <= cfg_data;
                        total_level <= shadow_level;
                        config_done <= 1'b1;
                    end else begin
                        index <= index + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule
